// File: rtl/minirisc_irq_ctrl_pkg.sv
// Shared definitions for the MiniRISC interrupt controller: FSM states,
// channel limits and the fixed-priority encoder.
package minirisc_irq_ctrl_pkg;

    localparam int unsigned MAX_IRQ  = 16;
    localparam int unsigned MAX_NEST = 8;

    typedef enum logic {
        IRQ_IDLE = 1'b0,
        IRQ_REQ  = 1'b1
    } irq_state_e;

    // Lowest set index among the first n bits of req; n when none is set.
    function automatic int unsigned prio_enc(input logic [MAX_IRQ-1:0] req,
                                             input int unsigned        n);
        int unsigned res;
        res = n;
        for (int unsigned i = 0; i < MAX_IRQ; i++) begin
            if (i < n && req[i] && res == n) begin
                res = i;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/minirisc_irq_ctrl_if.sv
// CPU-side handshake of the interrupt controller: request, vector and the
// ack/return pulses issued by the CPU controller FSM.
interface minirisc_irq_ctrl_if #(
    parameter int unsigned VEC_W = 4
);
    logic             cpu_irq;
    logic [VEC_W-1:0] vector;
    logic             cpu_int_ack;
    logic             cpu_int_ret;

    // CPU side
    modport master (
        input  cpu_irq,
        input  vector,
        output cpu_int_ack,
        output cpu_int_ret
    );

    // Interrupt controller side
    modport slave (
        output cpu_irq,
        output vector,
        input  cpu_int_ack,
        input  cpu_int_ret
    );
endinterface

// File: rtl/minirisc_irq_ctrl_stack.sv
// In-service LIFO: holds the ids of the ISRs currently running, innermost on
// top. A simultaneous push and pop replaces the top entry.
module minirisc_irq_ctrl_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               data_i,
    output logic [W-1:0]               top_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o,
    output logic                       full_o
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     stack_q [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop, do_push;
    int unsigned      wr_idx;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Next occupancy and write slot; pop-then-push lands on the old top slot.
    always_comb begin
        count_d = count_q;
        wr_idx  = 32'(count_q);
        if (do_pop) begin
            wr_idx = 32'(count_q) - 32'd1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Top-of-stack read mux.
    always_comb begin
        top_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i + 32'd1 == 32'(count_q)) begin
                top_o = stack_q[i];
            end
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (do_push && i == wr_idx) begin
                    stack_q[i] <= data_i;
                end
            end
        end
    end

endmodule

// File: rtl/minirisc_irq_ctrl.sv
// MiniRISC interrupt controller: synchronises NUM_IRQ request lines, latches
// edge/level requests, picks the highest-priority maskable winner that may
// pre-empt the running ISR, and tracks nesting in an in-service stack.
module minirisc_irq_ctrl
    import minirisc_irq_ctrl_pkg::*;
#(
    parameter int unsigned          NUM_IRQ    = 8,
    parameter int unsigned          NEST_DEPTH = 4,
    parameter logic [NUM_IRQ-1:0]   EDGE_MASK  = '1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_IRQ-1:0]              irq_in,
    input  logic                            mask_wr,
    input  logic [NUM_IRQ-1:0]              mask_din,
    output logic [NUM_IRQ-1:0]              mask,
    output logic [NUM_IRQ-1:0]              pending,
    output logic [$clog2(NEST_DEPTH+1)-1:0] nest_level,
    output logic                            ret_err,
    minirisc_irq_ctrl_if.slave              bus
);
    localparam int unsigned      VEC_W        = $clog2(NUM_IRQ + 1);
    localparam logic [VEC_W-1:0] VEC_SPURIOUS = VEC_W'(NUM_IRQ);

    logic [NUM_IRQ-1:0] sync1_q, sync2_q, dly_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] rise, eligible;
    irq_state_e         state_q;
    logic               cpu_irq_q;
    logic [VEC_W-1:0]   vector_q;
    logic               ret_err_q;

    logic [VEC_W-1:0]   winner_id, top_id;
    logic               presentable, push;
    logic               stk_empty, stk_full;

    assign rise      = sync2_q & ~dly_q;
    assign eligible  = pending_q & mask_q;
    assign winner_id = VEC_W'(prio_enc(MAX_IRQ'(eligible), NUM_IRQ));

    // A winner may only pre-empt a lower-priority ISR and only if there is room.
    assign presentable = (winner_id != VEC_SPURIOUS) && !stk_full &&
                         (stk_empty || winner_id < top_id);
    assign push        = bus.cpu_int_ack && presentable;

    assign mask        = mask_q;
    assign pending     = pending_q;
    assign ret_err     = ret_err_q;
    assign bus.cpu_irq = cpu_irq_q;
    assign bus.vector  = vector_q;

    // Pending next state: edge channels latch (set beats ack clear), level follow.
    always_comb begin
        pending_d = pending_q;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (EDGE_MASK[i]) begin
                if (rise[i]) begin
                    pending_d[i] = 1'b1;
                end else if (push && winner_id == VEC_W'(i)) begin
                    pending_d[i] = 1'b0;
                end
            end else begin
                pending_d[i] = sync2_q[i];
            end
        end
    end

    // Synchronisers, edge-detect delay, pending, mask and sticky return error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            dly_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            ret_err_q <= 1'b0;
        end else begin
            sync1_q   <= irq_in;
            sync2_q   <= sync1_q;
            dly_q     <= sync2_q;
            pending_q <= pending_d;
            if (mask_wr) begin
                mask_q <= mask_din;
            end
            if (bus.cpu_int_ret && stk_empty) begin
                ret_err_q <= 1'b1;
            end
        end
    end

    // Request FSM with registered cpu_irq and vector; ack forces one IDLE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IRQ_IDLE;
            cpu_irq_q <= 1'b0;
            vector_q  <= '0;
        end else if (bus.cpu_int_ack) begin
            vector_q  <= presentable ? winner_id : VEC_SPURIOUS;
            cpu_irq_q <= 1'b0;
            state_q   <= IRQ_IDLE;
        end else begin
            case (state_q)
                IRQ_IDLE: begin
                    cpu_irq_q <= 1'b0;
                    if (presentable) begin
                        state_q   <= IRQ_REQ;
                        cpu_irq_q <= 1'b1;
                    end
                end
                IRQ_REQ: begin
                    if (presentable) begin
                        cpu_irq_q <= 1'b1;
                    end else begin
                        cpu_irq_q <= 1'b0;
                        state_q   <= IRQ_IDLE;
                    end
                end
                default: begin
                    cpu_irq_q <= 1'b0;
                    state_q   <= IRQ_IDLE;
                end
            endcase
        end
    end

    minirisc_irq_ctrl_stack #(
        .DEPTH (NEST_DEPTH),
        .W     (VEC_W)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (bus.cpu_int_ret),
        .data_i  (winner_id),
        .top_o   (top_id),
        .count_o (nest_level),
        .empty_o (stk_empty),
        .full_o  (stk_full)
    );

endmodule
